// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: architectural constants, per-stage payload
// layouts with their reset/bubble images, and the stage-operation decode.
package pipe_pkg;

    localparam logic [31:0] RESET_PC  = 32'h1000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } de_payload_t;

    localparam int DE_WIDTH = $bits(de_payload_t);

    // Out of reset the Execute stage sees the reset PC so that PC-relative
    // logic downstream starts from a sane address even before valid rises.
    localparam de_payload_t DE_RESET_VALUE = '{
        pc:       RESET_PC,
        pc_plus4: RESET_PC + 32'd4,
        default:  '0
    };
    localparam de_payload_t DE_BUBBLE_VALUE = '0;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_HOLD  = 2'd1,
        OP_FLUSH = 2'd2
    } stage_op_t;

    // Flush outranks stall, which outranks a normal load.
    function automatic stage_op_t decode_op(input logic stall, input logic flush);
        if (flush)
            return OP_FLUSH;
        else if (stall)
            return OP_HOLD;
        else
            return OP_LOAD;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum instead of wrapping; a clear
// request wins over a simultaneous increment.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (inc && (cnt_reg != '1))
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with stall (hold) and flush (bubble) control,
// plus saturating stall/flush event counters for performance monitoring.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     d,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     q,
    output logic                 valid_out,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    stage_op_t            op;
    logic [WIDTH-1:0]     q_reg;
    logic                 valid_reg;
    logic [1:0]           cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_val [2];

    assign op = decode_op(stall, flush);

    // Payload loads even when valid_in is low; consumers gate on valid_out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_reg     <= RESET_VALUE;
            valid_reg <= 1'b0;
        end else begin
            unique case (op)
                OP_FLUSH: begin
                    q_reg     <= BUBBLE_VALUE;
                    valid_reg <= 1'b0;
                end
                OP_LOAD: begin
                    q_reg     <= d;
                    valid_reg <= valid_in;
                end
                default: begin
                    q_reg     <= q_reg;
                    valid_reg <= valid_reg;
                end
            endcase
        end
    end

    // Index 0 counts effective stalls, index 1 counts flushes.
    assign cnt_inc[0] = (op == OP_HOLD);
    assign cnt_inc[1] = (op == OP_FLUSH);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .n_rst (n_rst),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    assign q         = q_reg;
    assign valid_out = valid_reg;
    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg against a behavioural
// model; a wide-counter and a 2-bit-counter instance run side by side.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST_VAL = 32'h1000_0000;
    localparam logic [31:0] BUB_VAL = 32'h0000_0013;

    logic        clk;
    logic        n_rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [31:0] d;
    logic        cnt_clr;

    logic [31:0] q_a;
    logic        v_a;
    logic [15:0] sc_a;
    logic [15:0] fc_a;
    logic [31:0] q_b;
    logic        v_b;
    logic [1:0]  sc_b;
    logic [1:0]  fc_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state
    logic [31:0] m_q;
    logic        m_v;
    int          m_sc  [2];
    int          m_fc  [2];
    int          m_max [2] = '{65535, 3};

    pipe_stage_reg #(
        .WIDTH(32), .RESET_VALUE(RST_VAL), .BUBBLE_VALUE(BUB_VAL), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .n_rst(n_rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .d(d), .cnt_clr(cnt_clr), .q(q_a), .valid_out(v_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    pipe_stage_reg #(
        .WIDTH(32), .RESET_VALUE(RST_VAL), .BUBBLE_VALUE(BUB_VAL), .CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .n_rst(n_rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .d(d), .cnt_clr(cnt_clr), .q(q_b), .valid_out(v_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q = RST_VAL;
        m_v = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_sc[i] = 0;
            m_fc[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (flush) begin
            m_q = BUB_VAL;
            m_v = 1'b0;
        end else if (!stall) begin
            m_q = d;
            m_v = valid_in;
        end
        for (int i = 0; i < 2; i++) begin
            if (cnt_clr) begin
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else if (flush) begin
                m_fc[i] = (m_fc[i] < m_max[i]) ? m_fc[i] + 1 : m_max[i];
            end else if (stall) begin
                m_sc[i] = (m_sc[i] < m_max[i]) ? m_sc[i] + 1 : m_max[i];
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q_a"},  64'(q_a),  64'(m_q));
        check({tag, ".v_a"},  64'(v_a),  64'(m_v));
        check({tag, ".sc_a"}, 64'(sc_a), 64'(m_sc[0]));
        check({tag, ".fc_a"}, 64'(fc_a), 64'(m_fc[0]));
        check({tag, ".q_b"},  64'(q_b),  64'(m_q));
        check({tag, ".v_b"},  64'(v_b),  64'(m_v));
        check({tag, ".sc_b"}, 64'(sc_b), 64'(m_sc[1]));
        check({tag, ".fc_b"}, 64'(fc_b), 64'(m_fc[1]));
    endtask

    // Advance one edge, then compare 1 ns later; returns at the drive point.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("step %-8s stall=%0b flush=%0b clr=%0b vin=%0b d=%h -> q=%h v=%0b sc=%0d fc=%0d",
                 tag, stall, flush, cnt_clr, valid_in, d, q_a, v_a, sc_a, fc_a);
    endtask

    // Low pulse of about half a cycle, checked while reset is still asserted.
    task automatic reset_pulse(input string tag);
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        $display("reset %s -> q=%h v=%0b sc=%0d fc=%0d", tag, q_a, v_a, sc_a, fc_a);
        #4;
        n_rst = 1'b1;
    endtask

    task automatic drive(input logic s, input logic f, input logic c,
                         input logic vin, input logic [31:0] dv);
        stall    = s;
        flush    = f;
        cnt_clr  = c;
        valid_in = vin;
        d        = dv;
    endtask

    logic [1:0] sat_seq [6];

    initial begin
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        n_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset asserted between edges is visible before any edge
        #2;
        reset_pulse("rst0");
        check("rst0_q_lit", 64'(q_a), 64'(RST_VAL));

        // Load then stall three cycles with changing d
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
        step("load");
        check("load_q_lit", 64'(q_a), 64'h0000_0000_A5A5_0001);
        check("load_v_lit", 64'(v_a), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_q_lit", 64'(q_a), 64'h0000_0000_A5A5_0001);
        check("stall_cnt_lit", 64'(sc_a), 64'd3);

        // Flush wins over stall
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h7777_7777);
        step("flsh+stl");
        check("flush_q_lit", 64'(q_a), 64'(BUB_VAL));
        check("flush_v_lit", 64'(v_a), 64'd0);
        check("flush_cnt_lit", 64'(fc_a), 64'd1);
        check("flush_sc_lit", 64'(sc_a), 64'd3);

        // A single-cycle flush gives exactly one bubble
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
        step("post_fl");
        check("post_flush_v", 64'(v_a), 64'd1);

        // Saturation on the 2-bit instance
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step("clr");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step("sat");
            check("sat_seq", 64'(sc_b), 64'(sat_seq[i]));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step("clr+stl");
        check("clr_over_inc", 64'(sc_b), 64'd0);

        // Reset in the middle of a stall
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        step("load2");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step("stall2");
        step("stall2");
        check("hold_q_lit", 64'(q_a), 64'h0000_0000_1234_5678);
        reset_pulse("rst_mid");
        check("rst_mid_q_lit", 64'(q_a), 64'(RST_VAL));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
        step("rel_load");
        check("rel_load_q_lit", 64'(q_a), 64'h0000_0000_CAFE_0001);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 19) == 0), 1'($urandom), $urandom);
            if ($urandom_range(0, 49) == 0)
                reset_pulse("rnd_rst");
            step("rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed, always-loading stage flops between pipeline stages (e.g. Decode→Execute). It stores a WIDTH-bit packed payload plus a valid bit, and supports stall (hold) and flush (bubble insertion). Saturating stall and flush event counters feed performance monitoring. One instance per stage boundary, driven by the hazard unit.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- RESET_VALUE, 0: payload value loaded on reset; WIDTH bits.
- BUBBLE_VALUE, 0: payload value loaded on flush; WIDTH bits.
- CNT_WIDTH, 16: width of each event counter (≥2).

- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold current contents.
- flush  in  1  load bubble; overrides stall.
- valid_in  in  1  upstream stage holds a real instruction.
- d  in  WIDTH  packed payload from upstream.
- cnt_clr  in  1  synchronous clear of both counters.
- q  out  WIDTH  registered payload.
- valid_out  out  1  registered valid.
- stall_cnt  out  CNT_WIDTH  cycles in which a stall was applied.
- flush_cnt  out  CNT_WIDTH  cycles in which a flush was applied.

## Operation
- Per-cycle priority, highest first: flush, then stall, then load.
  - flush=1: q←BUBBLE_VALUE, valid_out←0 (stall ignored).
  - flush=0, stall=1: q and valid_out unchanged.
  - Otherwise: q←d, valid_out←valid_in.
- The payload is loaded whenever the stage loads, regardless of valid_in. Downstream must qualify all side effects with valid_out.
- Counters:
  - stall_cnt increments in a cycle with stall=1 and flush=0.
  - flush_cnt increments in a cycle with flush=1, including when stall=1 as well.
  - Both saturate at 2^CNT_WIDTH−1 and never wrap.
  - cnt_clr=1 sets both to 0 that cycle and overrides any increment. Payload and valid are unaffected.
- Reset (n_rst=0, at any time, mid-stall or mid-flush included), applied immediately without waiting for clk:
  - q=RESET_VALUE, valid_out=0, stall_cnt=0, flush_cnt=0.
  - Reset overrides all inputs.
  - On the first edge after deassertion, normal priority applies.

## Timing
- Latency: d/valid_in appear on q/valid_out one edge after a load cycle.
- Stall holds indefinitely with no loss of contents. Release resumes loading on the next edge.
- Flush takes effect at the next edge. A one-cycle flush yields exactly one bubble.
- Counter values reflect events up to and including the previous edge. The update is visible one cycle after the event.
- All outputs are direct flop outputs, with no combinational input→output path.

## Structure
- Shared package pipe_pkg holds:
  - RESET_PC (32'h1000_0000).
  - NOP_INSTR (32'h0000_0013).
  - Per-stage packed payload typedefs (de_payload_t: RD1, RD2, PC, ImmExt, PC_Plus4, Rs1, Rs2, Rd, funct3).
  - Per-stage reset/bubble constants built from them. RESET_VALUE for a DE payload places RESET_PC in the PC field and RESET_PC+4 in the PC_Plus4 field.
- Sub-module: sat_counter (CNT_WIDTH, inc, clr), instantiated twice for stall_cnt and flush_cnt.
- Payload and valid flops live in pipe_stage_reg itself.

## Test plan
- Reset: WIDTH=32, RESET_VALUE=32'h1000_0000, assert n_rst=0 between edges → q=32'h1000_0000, valid_out=0, both counters 0 immediately, before the next edge.
- Load/stall: load d=32'hA5A5_0001, valid_in=1 → q=32'hA5A5_0001 at edge 1. Stall 3 cycles with d=32'hFFFF_FFFF → q holds 32'hA5A5_0001 and stall_cnt=3.
- Flush vs. stall: stall=1 and flush=1 together for 1 cycle, BUBBLE_VALUE=32'h0000_0013 → q=32'h0000_0013, valid_out=0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_WIDTH=2, hold stall 6 cycles → stall_cnt goes 1,2,3,3,3,3. Then cnt_clr=1 and stall=1 together → stall_cnt=0.
- Reset mid-stall: after 2 stall cycles holding 32'h1234_5678, pulse n_rst low for half a cycle → q=RESET_VALUE, counters 0. The first edge after release loads d.
